// File: rtl/soc_flash_pkg.sv
// rtl/soc_flash_pkg.sv - SPI flash opcodes, boot/RX state enums and UART frame constants
package soc_flash_pkg;
    localparam logic [7:0] OP_WAKE = 8'hAB;
    localparam logic [7:0] OP_READ = 8'h03;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;
    localparam int WAKE_GAP_CLKS   = 8;

    typedef enum logic [2:0] {WAKE, CMD, READ, SEND, DONE, RUN} boot_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
endpackage

// File: rtl/soc_flash_boot_spi.sv
// rtl/soc_flash_boot_spi.sv - spi_flash_reader: mode-0 byte shifter with start/done handshake
module spi_flash_reader #(
    parameter int SPI_HALF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_req_i,
    input  logic       start_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       done_o,
    output logic       spi_cs_n_o,
    output logic       spi_clk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i
);
    localparam int HW = $clog2(SPI_HALF + 1);

    logic          cs_n_q, sclk_q, mosi_q, busy_q, done_q;
    logic [HW-1:0] hcnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    tx_q, rx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_q <= 1'b1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hcnt_q <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            cs_n_q <= ~cs_req_i;
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    busy_q <= 1'b1;
                    mosi_q <= wdata_i[7];
                    tx_q   <= {wdata_i[6:0], 1'b0};
                    hcnt_q <= '0;
                    bit_q  <= '0;
                end
            end else if (hcnt_q == HW'(SPI_HALF - 1)) begin
                hcnt_q <= '0;
                // miso is captured on the same clk edge that raises spi_clk
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                    rx_q   <= {rx_q[6:0], spi_miso_i};
                end else begin
                    sclk_q <= 1'b0;
                    mosi_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b0};
                    bit_q  <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            end else begin
                hcnt_q <= hcnt_q + HW'(1);
            end
        end
    end

    assign rdata_o    = rx_q;
    assign done_o     = done_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;
endmodule

// File: rtl/soc_flash_boot.sv
// rtl/soc_flash_boot.sv - flash banner boot and UART console top; SOC_ECHO_EN enables RX echo
module soc_flash_boot
    import soc_flash_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 217,
    parameter logic [23:0] FLASH_ADDR   = 24'h100000,
    parameter int          BANNER_LEN   = 16,
    parameter int          SPI_HALF     = 1
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       spi_cs_n,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    input  logic       RXD,
    output logic       TXD,
    output logic [4:0] LEDS
);
    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic       spi_start, spi_done, cs_req;
    logic [7:0] spi_wdata, spi_rdata;

    spi_flash_reader #(.SPI_HALF(SPI_HALF)) u_spi (
        .clk        (clk),
        .rst        (resetn),
        .cs_req_i   (cs_req),
        .start_i    (spi_start),
        .wdata_i    (spi_wdata),
        .rdata_o    (spi_rdata),
        .done_o     (spi_done),
        .spi_cs_n_o (spi_cs_n),
        .spi_clk_o  (spi_clk),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso)
    );

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_valid_q, rx_valid_d;
    logic [4:0]    leds_q;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
            leds_q     <= '0;
        end else begin
            rx_s1_q    <= RXD;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            if (rx_valid_q) leds_q <= rx_sh_q[4:0];
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'(UART_DATA_BITS - 1)) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                if (rx_s2_q) begin
                    rx_valid_d = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                rx_cnt_d = '0;
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    logic          tx_start, tx_busy_q, txd_q;
    logic [7:0]    tx_data;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [8:0]    tx_sh_q;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            tx_busy_q <= 1'b0;
            txd_q     <= 1'b1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '1;
        end else if (tx_start) begin
            tx_busy_q <= 1'b1;
            txd_q     <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= {1'b1, tx_data};
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'(UART_FRAME_BITS - 1)) begin
                    tx_busy_q <= 1'b0;
                    txd_q     <= 1'b1;
                end else begin
                    txd_q    <= tx_sh_q[0];
                    tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CW'(1);
            end
        end
    end

`ifdef SOC_ECHO_EN
    logic [7:0] echo_q;
    logic       echo_full_q, echo_take;

    // a byte landing in the same clock as an echo start refills the buffer
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            echo_q      <= '0;
            echo_full_q <= 1'b0;
        end else if (rx_valid_q) begin
            echo_q      <= rx_sh_q;
            echo_full_q <= 1'b1;
        end else if (echo_take) begin
            echo_full_q <= 1'b0;
        end
    end
`endif

    boot_state_t state_q, state_d;
    logic        issued_q, issued_d, wgap_q, wgap_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  gap_q, gap_d;
    logic [7:0]  sent_q, sent_d;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q  <= WAKE;
            issued_q <= 1'b0;
            wgap_q   <= 1'b0;
            idx_q    <= '0;
            gap_q    <= '0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            wgap_q   <= wgap_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            sent_q   <= sent_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        wgap_d    = wgap_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        sent_d    = sent_q;
        spi_start = 1'b0;
        spi_wdata = 8'h00;
        cs_req    = 1'b0;
        tx_start  = 1'b0;
        tx_data   = 8'h00;
`ifdef SOC_ECHO_EN
        echo_take = 1'b0;
`endif
        case (state_q)
            WAKE: begin
                if (!wgap_q) begin
                    cs_req    = 1'b1;
                    spi_wdata = OP_WAKE;
                    if (!issued_q) begin
                        spi_start = 1'b1;
                        issued_d  = 1'b1;
                    end else if (spi_done) begin
                        issued_d = 1'b0;
                        wgap_d   = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 3'd1;
                    if (gap_q == 3'(WAKE_GAP_CLKS - 1)) begin
                        wgap_d  = 1'b0;
                        state_d = CMD;
                    end
                end
            end
            CMD: begin
                cs_req = 1'b1;
                case (idx_q)
                    2'd0:    spi_wdata = OP_READ;
                    2'd1:    spi_wdata = FLASH_ADDR[23:16];
                    2'd2:    spi_wdata = FLASH_ADDR[15:8];
                    default: spi_wdata = FLASH_ADDR[7:0];
                endcase
                if (!issued_q) begin
                    spi_start = 1'b1;
                    issued_d  = 1'b1;
                end else if (spi_done) begin
                    issued_d = 1'b0;
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = READ;
                end
            end
            READ: begin
                cs_req = 1'b1;
                if (!issued_q) begin
                    spi_start = 1'b1;
                    issued_d  = 1'b1;
                end else if (spi_done) begin
                    issued_d = 1'b0;
                    if (spi_rdata == 8'h00) begin
                        state_d = DONE;
                    end else begin
                        tx_start = 1'b1;
                        tx_data  = spi_rdata;
                        state_d  = SEND;
                    end
                end
            end
            SEND: begin
                cs_req = 1'b1;
                if (!tx_busy_q) begin
                    sent_d  = sent_q + 8'd1;
                    state_d = (sent_q + 8'd1 == 8'(BANNER_LEN)) ? DONE : READ;
                end
            end
            DONE: state_d = RUN;
            RUN: begin
`ifdef SOC_ECHO_EN
                if (echo_full_q && !tx_busy_q) begin
                    tx_start  = 1'b1;
                    tx_data   = echo_q;
                    echo_take = 1'b1;
                end
`endif
            end
            default: state_d = WAKE;
        endcase
    end

    assign TXD  = txd_q;
    assign LEDS = leds_q;
endmodule

// File: tb/tb_soc_flash_boot.sv
// tb/tb_soc_flash_boot.sv - scoreboard bench: banner, console, framing error, mid-frame reset
`timescale 1ns/1ps
module tb_soc_flash_boot;
    localparam int CPB   = 16;
    localparam int SPI_H = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       spi_cs_n, spi_clk, spi_mosi;
    logic       spi_miso = 1'b0;
    logic       RXD = 1'b1;
    logic       TXD;
    logic [4:0] LEDS;

    always #20 clk = ~clk;

    soc_flash_boot #(
        .CLKS_PER_BIT (CPB),
        .FLASH_ADDR   (24'h100000),
        .BANNER_LEN   (16),
        .SPI_HALF     (SPI_H)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .RXD      (RXD),
        .TXD      (TXD),
        .LEDS     (LEDS)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_cmd[$];
    logic [4:0] exp_leds[$];
    logic [7:0] mem[0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    // Flash model: command bytes checked as they arrive, read data driven on falling spi_clk
    int          fbits = 0;
    int          last_bits = 0;
    logic [31:0] fsh = '0;

    always @(posedge spi_clk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            last_bits = fbits;
            fbits = 0;
        end else begin
            fsh = {fsh[30:0], spi_mosi};
            fbits++;
            if (fbits == 8) begin
                if (exp_cmd.size() == 0) fail_now("flash_cmd_extra", fsh[7:0]);
                else check("flash_cmd", fsh[7:0], exp_cmd.pop_front());
            end
            if (fbits == 32 && fsh[31:24] == 8'h03) check("flash_addr", fsh[23:0], 32'h100000);
        end
    end

    always @(negedge spi_clk) begin
        int r;
        if (!spi_cs_n && fbits >= 32) begin
            r = fbits - 32;
            spi_miso = (r / 8 < 16) ? mem[r / 8][7 - (r % 8)] : 1'b0;
        end
    end

    int         tx_st = 0;
    int         tx_cnt = 0;
    logic [7:0] tx_b = '0;

    always @(negedge clk) begin
        if (resetn) begin
            tx_st = 0;
        end else if (tx_st == 0) begin
            if (TXD == 1'b0) begin
                tx_st  = 1;
                tx_cnt = 0;
            end
        end else begin
            tx_cnt++;
            if (tx_cnt % CPB == CPB / 2) begin
                if (tx_cnt / CPB >= 1 && tx_cnt / CPB <= 8) begin
                    tx_b = {TXD, tx_b[7:1]};
                end else if (tx_cnt / CPB == 9) begin
                    check("tx_stop", TXD, 1);
                    if (exp_tx.size() == 0) fail_now("tx_unexpected", tx_b);
                    else check("tx_byte", tx_b, exp_tx.pop_front());
                    tx_st = 0;
                end
            end
        end
    end

    logic [4:0] led_prev = '0;

    always @(negedge clk) begin
        if (resetn) begin
            led_prev = LEDS;
        end else if (LEDS !== led_prev) begin
            if (exp_leds.size() == 0) fail_now("leds_unexpected", LEDS);
            else check("leds", LEDS, exp_leds.pop_front());
            led_prev = LEDS;
        end
    end

    task automatic uart_send(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RXD = stop;
        repeat (CPB) @(negedge clk);
        RXD = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_tx.size() + exp_leds.size() + exp_cmd.size()) != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_tx.size() + exp_leds.size() + exp_cmd.size(), 0);
    endtask

    task automatic wait_tx_left(input string name, input int n, input int budget);
        int t;
        t = 0;
        while (exp_tx.size() > n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_tx.size() <= n, 1);
    endtask

    task automatic load_hello();
        logic [7:0] hello[0:6];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A, 8'h00};
        for (int i = 0; i < 16; i++) mem[i] = (i < 7) ? hello[i] : 8'h55;
    endtask

    task automatic push_hello();
        exp_tx.push_back(8'h48); exp_tx.push_back(8'h65); exp_tx.push_back(8'h6C);
        exp_tx.push_back(8'h6C); exp_tx.push_back(8'h6F); exp_tx.push_back(8'h0A);
    endtask

    initial begin
        logic [7:0] rx_bytes[0:5];
        logic [4:0] rx_leds[0:5];
        int         t;
        rx_bytes = '{8'h34, 8'h2A, 8'h34, 8'h39, 8'h2F, 8'h30};
        rx_leds  = '{5'b10100, 5'b01010, 5'b10100, 5'b11001, 5'b01111, 5'b10000};

        load_hello();
        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_spi_clk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_txd", TXD, 1);
        check("rst_leds", LEDS, 0);

        exp_cmd.push_back(8'hAB);
        exp_cmd.push_back(8'h03);
        push_hello();
        resetn = 1'b0;
        wait_drain("banner1_drain", 4000);
        repeat (100) @(negedge clk);
        check("banner1_cs_idle", spi_cs_n, 1);
        check("banner1_read_bits", last_bits, 88);

        for (int i = 0; i < 6; i++) begin
            exp_leds.push_back(rx_leds[i]);
`ifdef SOC_ECHO_EN
            exp_tx.push_back(rx_bytes[i]);
`endif
            uart_send(rx_bytes[i], 1'b1);
        end
        wait_drain("console_drain", 3000);

        uart_send(8'h34, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        check("frame_err_leds", LEDS, 5'b10000);

        resetn = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h41 + 8'(i);
        repeat (3) @(negedge clk);
        exp_cmd.push_back(8'hAB);
        exp_cmd.push_back(8'h03);
        for (int i = 0; i < 16; i++) exp_tx.push_back(8'h41 + 8'(i));
`ifdef SOC_ECHO_EN
        exp_tx.push_back(8'h41);
`endif
        resetn = 1'b0;
        wait_tx_left("banner16_progress", 14, 3000);
        exp_leds.push_back(5'b00001);
        uart_send(8'h41, 1'b1);
        wait_drain("banner16_drain", 8000);
        repeat (200) @(negedge clk);
        check("banner16_cs_idle", spi_cs_n, 1);
        check("banner16_read_bits", last_bits, 160);

        resetn = 1'b1;
        load_hello();
        repeat (3) @(negedge clk);
        exp_cmd.push_back(8'hAB);
        exp_cmd.push_back(8'h03);
        push_hello();
        resetn = 1'b0;
        wait_tx_left("midrst_first_byte", 5, 3000);
        t = 0;
        while (TXD !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("midrst_second_start", TXD, 0);
        repeat (3 * CPB) @(negedge clk);
        #3 resetn = 1'b1;
        #1;
        check("midrst_txd", TXD, 1);
        check("midrst_cs_n", spi_cs_n, 1);
        check("midrst_spi_clk", spi_clk, 0);
        exp_tx.delete();
        exp_cmd.delete();
        exp_cmd.push_back(8'hAB);
        exp_cmd.push_back(8'h03);
        push_hello();
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        wait_drain("rerun_drain", 4000);
        repeat (100) @(negedge clk);
        check("rerun_read_bits", last_bits, 88);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/soc_flash_boot.md
# soc_flash_boot

Small boot/console controller for the flash-based SoC top level. Wakes an external SPI NOR flash, streams a boot banner from it over a UART, then runs a console loop. In the console loop it accepts UART bytes, shows each byte on the LEDs and optionally echoes it. It sits between the board pins (flash SPI, UART, LEDs) and the rest of the SoC, and needs no CPU to operate.

## Interface
Parameters:
- CLKS_PER_BIT, 217: system clocks per UART bit (25 MHz / 115200).
- FLASH_ADDR, 24'h100000: 24-bit flash byte address of the banner.
- BANNER_LEN, 16: maximum number of banner bytes to read (1..255).
- SPI_HALF, 1: system clocks per SPI clock half-period (minimum 1).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, 25 MHz nominal.
- resetn  in  1  asynchronous reset, active-high despite the port name.
- spi_cs_n  out  1  flash chip select, active-low.
- spi_clk  out  1  SPI clock, mode 0 (idle low).
- spi_mosi  out  1  controller-to-flash data.
- spi_miso  in  1  flash-to-controller data.
- RXD  in  1  UART receive, 8N1, idle high, asynchronous to clk.
- TXD  out  1  UART transmit, 8N1, idle high.
- LEDS  out  5  bits [4:0] of the last valid received byte.

## Operation
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, TXD=1, LEDS=0. The FSM is in WAKE, and all counters and the echo buffer are cleared.
- WAKE: assert cs, shift out 0xAB (release power-down), deassert cs. Then hold cs high for 8 clocks and go to CMD.
- CMD: assert cs and shift out 0x03 followed by FLASH_ADDR, MSB first, 32 bits in total.
- READ: shift in 8 bits MSB first. Then stop spi_clk low with cs still asserted.
  - A byte of 0x00 ends the banner.
  - Any other byte goes to SEND.
- SEND: transmit the byte on TXD and wait for the transmitter to go idle.
  - If BANNER_LEN bytes have now been sent, go to DONE.
  - Otherwise go back to READ.
- DONE: deassert cs and go to RUN. spi_clk stays low and spi_mosi stays 0 from this point.
- RUN: console loop. The FSM never leaves RUN except through reset.
- SPI shifting:
  - mosi changes while spi_clk is low.
  - miso is sampled on the clk edge that raises spi_clk.
  - Each SPI bit takes 2*SPI_HALF clocks.
- UART RX:
  - RXD passes through a 2-flop synchronizer.
  - A falling edge starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if RXD is high there, the frame is a glitch and is ignored.
  - Data bits are sampled at the centre of each bit, LSB first.
  - Stop bit = 1: the byte is valid. LEDS is updated one clock after the stop-bit sample.
  - Stop bit = 0: framing error. The byte is discarded and the receiver waits for RXD high before looking for a new frame.
- RX is active in all states, including during the banner.
- UART TX: start bit, 8 data bits LSB first, stop bit; each bit lasts CLKS_PER_BIT clocks.
- Echo buffer: one entry.
  - A valid RX byte overwrites the buffer (latest byte wins).
  - The buffer is transmitted only in RUN, and only when TX is idle.

## Timing
- Wake, command and read phases: one SPI bit per 2*SPI_HALF clocks.
- The first banner start bit appears within 4 clocks of the 8th data bit being sampled.
- One TX frame is 10*CLKS_PER_BIT clocks (2170 at default).
- Echo start bit begins within 3 clocks of LEDS updating, if TX is idle and the FSM is in RUN.
- Reset asserted mid-operation:
  - All outputs return to reset values asynchronously.
  - A partial UART frame is truncated and a partial SPI transfer is abandoned with cs high.
  - The wake sequence restarts on release.
- Simultaneous valid RX byte and an echo TX start in the same clock: the new byte is buffered for the next echo.

## Configuration
- SOC_ECHO_EN defined: valid RX bytes are echoed on TXD as described under Operation.
- SOC_ECHO_EN undefined: no echo. TXD carries only the banner, LEDS behaviour is unchanged, and the echo buffer is not instantiated.

## Structure
- Shared package soc_flash_pkg holds:
  - SPI opcodes: OP_WAKE=8'hAB, OP_READ=8'h03.
  - The FSM state enum: WAKE, CMD, READ, SEND, DONE, RUN.
  - The UART frame constants.
- One sub-module: spi_flash_reader, which handles cs, clk and the byte shift in and out, with a start/done handshake. The UART RX, UART TX and the FSM stay in the top level.

## Test plan
- Flash model holds "Hello\n" then 0x00 at 0x100000, BANNER_LEN=16 -> exactly 6 bytes on TXD, 0x48 first; flash sees 0xAB, then 0x03 10 00 00.
- Flash with 16 non-zero bytes and no terminator, BANNER_LEN=16 -> 16 bytes transmitted, then cs stays high.
- After the banner, RXD sends 0x34, 0x2A, 0x34, 0x39, 0x2F, 0x30 at 8680 ns/bit -> LEDS = 10100, 01010, 10100, 11001, 01111, 10000 in turn; with SOC_ECHO_EN, TXD echoes the same six bytes.
- 0x34 received with stop bit forced 0 -> LEDS unchanged, no echo.
- 0x41 received during the banner -> LEDS=00001 immediately; the echo 0x41 follows the last banner byte.
- Reset pulse during a TX frame -> TXD=1 and spi_cs_n=1 immediately; the wake sequence 0xAB repeats after release.
